// File: rtl/vram_fetch_arbiter.sv
// rtl/vram_fetch_arbiter.sv - round-robin VRAM read arbiter for three 32-bit fetch masters
module vram_fetch_arbiter #(
  parameter int RAM_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [14:0] m0_addr,
  input  logic        m0_strobe,
  output logic        m0_ack,
  input  logic [14:0] m1_addr,
  input  logic        m1_strobe,
  output logic        m1_ack,
  input  logic [14:0] m2_addr,
  input  logic        m2_strobe,
  output logic        m2_ack,
  output logic [31:0] rddata,
  output logic [14:0] ram_addr,
  output logic        ram_rden,
  input  logic [31:0] ram_rddata
);

  // One tag per issued read, travelling alongside the RAM data.
  typedef struct packed {
    logic       valid;
    logic [1:0] port;
  } tag_t;

  tag_t        tag_pipe [RAM_LATENCY];
  tag_t        exit_tag;
  logic [1:0]  rr_ptr;
  logic [2:0]  in_flight;
  logic [2:0]  eligible;
  logic [2:0]  ack_r;
  logic [3:0]  elig_pad;
  logic [2:0]  cand;
  logic        grant_valid;
  logic [1:0]  grant_port;
  logic [2:0]  grant_onehot;
  logic [14:0] grant_addr;
  logic [2:0]  exit_onehot;

  // A port already waiting on data is never re-granted, even if its strobe is still up.
  assign eligible = {m2_strobe, m1_strobe, m0_strobe} & ~in_flight;
  assign exit_tag = tag_pipe[RAM_LATENCY-1];

  assign m0_ack = ack_r[0];
  assign m1_ack = ack_r[1];
  assign m2_ack = ack_r[2];

  // Round-robin search over eligible ports starting at rr_ptr.
  always_comb begin
    grant_valid = 1'b0;
    grant_port  = 2'd0;
    cand        = 3'd0;
    elig_pad    = {1'b0, eligible};
    for (int k = 0; k < 3; k++) begin
      cand = {1'b0, rr_ptr} + 3'(k);
      if (cand >= 3'd3) begin
        cand = cand - 3'd3;
      end
      if (!grant_valid && elig_pad[cand[1:0]]) begin
        grant_valid = 1'b1;
        grant_port  = cand[1:0];
      end
    end
  end

  // Decode the winning port into its address and a one-hot in_flight set mask.
  always_comb begin
    grant_onehot = 3'b000;
    grant_addr   = m0_addr;
    case (grant_port)
      2'd0: begin
        grant_onehot = 3'b001;
        grant_addr   = m0_addr;
      end
      2'd1: begin
        grant_onehot = 3'b010;
        grant_addr   = m1_addr;
      end
      default: begin
        grant_onehot = 3'b100;
        grant_addr   = m2_addr;
      end
    endcase
    if (!grant_valid) begin
      grant_onehot = 3'b000;
    end
  end

  // Decode the tag leaving the pipeline into the port to acknowledge.
  always_comb begin
    exit_onehot = 3'b000;
    if (exit_tag.valid) begin
      case (exit_tag.port)
        2'd0:    exit_onehot = 3'b001;
        2'd1:    exit_onehot = 3'b010;
        2'd2:    exit_onehot = 3'b100;
        default: exit_onehot = 3'b000;
      endcase
    end
  end

  // Issue the granted read, advance the tag pipeline and return data with a one-cycle ack.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ram_rden  <= 1'b0;
      ram_addr  <= '0;
      ack_r     <= 3'b000;
      rddata    <= '0;
      rr_ptr    <= 2'd0;
      in_flight <= 3'b000;
      for (int k = 0; k < RAM_LATENCY; k++) begin
        tag_pipe[k] <= '0;
      end
    end else begin
      ram_rden    <= grant_valid;
      tag_pipe[0] <= '{valid: grant_valid, port: grant_port};
      for (int k = 1; k < RAM_LATENCY; k++) begin
        tag_pipe[k] <= tag_pipe[k-1];
      end
      if (grant_valid) begin
        ram_addr <= grant_addr;
        rr_ptr   <= (grant_port == 2'd2) ? 2'd0 : grant_port + 2'd1;
      end
      ack_r <= exit_onehot;
      if (exit_tag.valid) begin
        rddata <= ram_rddata;
      end
      in_flight <= (in_flight | grant_onehot) & ~exit_onehot;
    end
  end

endmodule

// File: tb/tb_vram_fetch_arbiter.sv
// tb/tb_vram_fetch_arbiter.sv - directed vector bench for vram_fetch_arbiter
module tb_vram_fetch_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  s_drv = 3'b000;
  logic        auto_mode = 1'b0;
  logic [14:0] a0 = 15'h0100;
  logic [14:0] a1 = 15'h0200;
  logic [14:0] a2 = 15'h1234;
  logic [2:0]  strobe;

  logic [2:0]        rden_v;
  logic [2:0][14:0]  raddr_v;
  logic [2:0][2:0]   ack_v;
  logic [2:0][31:0]  rd_v;
  logic [31:0]       rdat0, rdat1, rdat2;
  logic [31:0]       p2, q1, q2;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [2:0]  s;
    logic        rden;
    logic [14:0] addr;
    logic [2:0]  ack;
    logic [31:0] rd;
  } vec_t;

  vec_t tbl [16];

  always #5 clk = ~clk;

  // RAM contents: a fixed function of the word address.
  function automatic logic [31:0] dfun(input logic [14:0] a);
    if (a == 15'h1234) return 32'hDEADBEEF;
    return {~a[7:0], 1'b0, a, 8'hC3};
  endfunction

  function automatic int port_of(input logic [14:0] a);
    if (a == 15'h0100) return 0;
    if (a == 15'h0200) return 1;
    if (a == 15'h1234) return 2;
    return 3;
  endfunction

  // Self-gating masters for the fairness run follow the latency-1 instance's acks.
  assign strobe = auto_mode ? ~ack_v[0] : s_drv;

  // RAM models of latency 1, 2 and 3.
  assign rdat0 = rden_v[0] ? dfun(raddr_v[0]) : 32'h0;
  always @(posedge clk) begin
    p2 <= rden_v[1] ? dfun(raddr_v[1]) : 32'h0;
    q1 <= rden_v[2] ? dfun(raddr_v[2]) : 32'h0;
    q2 <= q1;
  end
  assign rdat1 = p2;
  assign rdat2 = q2;

  vram_fetch_arbiter #(.RAM_LATENCY(1)) u1 (
    .clk(clk), .rst_n(rst_n),
    .m0_addr(a0), .m0_strobe(strobe[0]), .m0_ack(ack_v[0][0]),
    .m1_addr(a1), .m1_strobe(strobe[1]), .m1_ack(ack_v[0][1]),
    .m2_addr(a2), .m2_strobe(strobe[2]), .m2_ack(ack_v[0][2]),
    .rddata(rd_v[0]), .ram_addr(raddr_v[0]), .ram_rden(rden_v[0]), .ram_rddata(rdat0)
  );

  vram_fetch_arbiter #(.RAM_LATENCY(2)) u2 (
    .clk(clk), .rst_n(rst_n),
    .m0_addr(a0), .m0_strobe(strobe[0]), .m0_ack(ack_v[1][0]),
    .m1_addr(a1), .m1_strobe(strobe[1]), .m1_ack(ack_v[1][1]),
    .m2_addr(a2), .m2_strobe(strobe[2]), .m2_ack(ack_v[1][2]),
    .rddata(rd_v[1]), .ram_addr(raddr_v[1]), .ram_rden(rden_v[1]), .ram_rddata(rdat1)
  );

  vram_fetch_arbiter #(.RAM_LATENCY(3)) u3 (
    .clk(clk), .rst_n(rst_n),
    .m0_addr(a0), .m0_strobe(strobe[0]), .m0_ack(ack_v[2][0]),
    .m1_addr(a1), .m1_strobe(strobe[1]), .m1_ack(ack_v[2][1]),
    .m2_addr(a2), .m2_strobe(strobe[2]), .m2_ack(ack_v[2][2]),
    .rddata(rd_v[2]), .ram_addr(raddr_v[2]), .ram_rden(rden_v[2]), .ram_rddata(rdat2)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_rng(input string name, input int act, input int lo, input int hi);
    total++;
    if (act < lo || act > hi) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    s_drv = 3'b000;
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    int nxt, grants, dbl, order_err, rd_err, rdens, acks, lat;
    int cnt [3];
    logic [2:0] ea;

    tbl[0]  = '{3'b000, 1'b0, 15'h0000, 3'b000, 32'h00000000};
    tbl[1]  = '{3'b100, 1'b1, 15'h1234, 3'b000, 32'h00000000};
    tbl[2]  = '{3'b100, 1'b0, 15'h1234, 3'b100, 32'hDEADBEEF};
    tbl[3]  = '{3'b000, 1'b0, 15'h1234, 3'b000, 32'hDEADBEEF};
    tbl[4]  = '{3'b111, 1'b1, 15'h0100, 3'b000, 32'hDEADBEEF};
    tbl[5]  = '{3'b111, 1'b1, 15'h0200, 3'b001, 32'hFF0100C3};
    tbl[6]  = '{3'b111, 1'b1, 15'h1234, 3'b010, 32'hFF0200C3};
    tbl[7]  = '{3'b111, 1'b1, 15'h0100, 3'b100, 32'hDEADBEEF};
    tbl[8]  = '{3'b000, 1'b0, 15'h0100, 3'b001, 32'hFF0100C3};
    tbl[9]  = '{3'b101, 1'b1, 15'h1234, 3'b000, 32'hFF0100C3};
    tbl[10] = '{3'b001, 1'b1, 15'h0100, 3'b100, 32'hDEADBEEF};
    tbl[11] = '{3'b000, 1'b0, 15'h0100, 3'b001, 32'hFF0100C3};
    tbl[12] = '{3'b001, 1'b1, 15'h0100, 3'b000, 32'hFF0100C3};
    tbl[13] = '{3'b010, 1'b1, 15'h0200, 3'b001, 32'hFF0100C3};
    tbl[14] = '{3'b000, 1'b0, 15'h0200, 3'b010, 32'hFF0200C3};
    tbl[15] = '{3'b000, 1'b0, 15'h0200, 3'b000, 32'hFF0200C3};

    // Reset held with all strobes high, then release: m0 wins first.
    rst_n = 1'b0;
    s_drv = 3'b111;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("rst_rden%0d", i), 32'(rden_v[0]), 32'h0);
      chk($sformatf("rst_ack%0d", i), 32'(ack_v[0]), 32'h0);
      chk($sformatf("rst_rddata%0d", i), rd_v[0], 32'h0);
    end
    rst_n = 1'b1;
    step();
    chk("release_rden", 32'(rden_v[0]), 32'h1);
    chk("release_addr_m0", 32'(raddr_v[0]), 32'(a0));
    rst_n = 1'b0;
    s_drv = 3'b000;
    step();
    rst_n = 1'b1;

    // Vector table on the latency-1 instance.
    for (int i = 0; i < 16; i++) begin
      s_drv = tbl[i].s;
      step();
      chk($sformatf("v%0d_rden", i), 32'(rden_v[0]), 32'(tbl[i].rden));
      chk($sformatf("v%0d_addr", i), 32'(raddr_v[0]), 32'(tbl[i].addr));
      chk($sformatf("v%0d_ack", i), 32'(ack_v[0]), 32'(tbl[i].ack));
      chk($sformatf("v%0d_rddata", i), rd_v[0], tbl[i].rd);
    end

    // Fairness: three self-gating masters for 30 cycles.
    do_reset();
    auto_mode = 1'b1;
    nxt = 0; grants = 0; dbl = 0; order_err = 0; rd_err = 0;
    cnt[0] = 0; cnt[1] = 0; cnt[2] = 0;
    for (int c = 0; c < 30; c++) begin
      step();
      if (rden_v[0]) begin
        grants++;
        if (port_of(raddr_v[0]) != nxt) order_err++;
        nxt = (nxt + 1) % 3;
      end
      if ($countones(ack_v[0]) > 1) dbl++;
      for (int p = 0; p < 3; p++) begin
        if (ack_v[0][p]) begin
          cnt[p]++;
          if (rd_v[0] !== dfun(p == 0 ? a0 : (p == 1 ? a1 : a2))) rd_err++;
        end
      end
    end
    auto_mode = 1'b0;
    chk("fair_grants", grants, 30);
    chk("fair_order_err", order_err, 0);
    chk("fair_double_ack", dbl, 0);
    chk("fair_rddata_err", rd_err, 0);
    for (int p = 0; p < 3; p++) chk_rng($sformatf("fair_acks_m%0d", p), cnt[p], 9, 11);

    // Latency sweep: back-to-back m0 then m1 on all three latencies.
    do_reset();
    s_drv = 3'b011;
    for (int c = 1; c <= 6; c++) begin
      step();
      if (c == 2) s_drv = 3'b000;
      for (int k = 0; k < 3; k++) begin
        lat = k + 1;
        ea = (c == lat + 1) ? 3'b001 : ((c == lat + 2) ? 3'b010 : 3'b000);
        chk($sformatf("lat%0d_c%0d_rden", lat, c), 32'(rden_v[k]), (c <= 2) ? 32'h1 : 32'h0);
        chk($sformatf("lat%0d_c%0d_ack", lat, c), 32'(ack_v[k]), 32'(ea));
        if (c <= 2) chk($sformatf("lat%0d_c%0d_addr", lat, c), 32'(raddr_v[k]), (c == 1) ? 32'(a0) : 32'(a1));
        if (ea == 3'b001) chk($sformatf("lat%0d_rd_m0", lat), rd_v[k], dfun(a0));
        if (ea == 3'b010) chk($sformatf("lat%0d_rd_m1", lat), rd_v[k], dfun(a1));
      end
    end

    // Late strobe drop on latency 3: strobe stays up until ack is seen.
    do_reset();
    s_drv = 3'b001;
    rdens = 0; acks = 0;
    for (int c = 0; c < 10; c++) begin
      step();
      if (rden_v[2]) rdens++;
      if (ack_v[2][0]) begin
        acks++;
        s_drv = 3'b000;
      end
    end
    s_drv = 3'b000;
    chk("late_drop_rden_count", rdens, 1);
    chk("late_drop_ack_count", acks, 1);

    // Reset one cycle after m1 is granted on latency 3: that access is dropped.
    do_reset();
    s_drv = 3'b010;
    step();
    chk("midrst_grant", 32'(rden_v[2]), 32'h1);
    s_drv = 3'b000;
    rst_n = 1'b0;
    step();
    chk("midrst_rden_cleared", 32'(rden_v[2]), 32'h0);
    rst_n = 1'b1;
    acks = 0;
    for (int c = 0; c < 8; c++) begin
      step();
      if (ack_v[2][1]) acks++;
    end
    chk("midrst_no_ack", acks, 0);
    s_drv = 3'b010;
    lat = 0;
    for (int c = 1; c <= 8; c++) begin
      step();
      s_drv = 3'b000;
      if (ack_v[2][1] && lat == 0) begin
        lat = c;
        chk("midrst_rddata", rd_v[2], dfun(a1));
      end
    end
    chk("midrst_new_latency", lat, 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vram_fetch_arbiter.md
# vram_fetch_arbiter

VRAM read responder serving the 32-bit fetch ports of the layer renderers and the sprite renderer. Accepts strobe/address requests from three bus masters, arbitrates round-robin, issues one read per cycle to the VRAM data port, and returns the word with a single-cycle ack to the requesting master. Sits between the graphics renderers and the VRAM, replacing per-master point-to-point wiring.

## Interface
- RAM_LATENCY, 1, cycles from ram_rden to valid ram_rddata; legal values 1..3
- clk  in  1  system clock; all logic on rising edge
- rst_n  in  1  synchronous reset, active low
- m0_addr  in  15  layer 0 word address (32-bit words, 128 KB space)
- m0_strobe  in  1  layer 0 request; held until ack
- m0_ack  out  1  layer 0 data-valid pulse
- m1_addr / m1_strobe / m1_ack  in/in/out  15/1/1  layer 1, same meaning
- m2_addr / m2_strobe / m2_ack  in/in/out  15/1/1  sprite renderer, same meaning
- rddata  out  32  read word, shared by all masters; valid only with the asserted ack
- ram_addr  out  15  VRAM word address
- ram_rden  out  1  VRAM read enable
- ram_rddata  in  32  VRAM read data, valid RAM_LATENCY cycles after ram_rden

## Operation
- Masters gate strobe with their own ack (strobe_out = strobe_r && !ack) and drop it the cycle after ack; arbiter never sees a re-request of an acked access.
- Per-port in_flight flag set on grant, cleared on ack; a port with in_flight=1 is excluded from arbitration even if strobe is high (protects against masters that gate strobe late).
- Arbitration each cycle over eligible ports (strobe && !in_flight): round-robin, search starting at rr_ptr, rr_ptr <= granted+1 mod 3. No eligible port: no grant, rr_ptr unchanged.
- Grant cycle: ram_addr <= granted port addr, ram_rden <= 1, pipeline tag {valid, port[1:0]} entered into a RAM_LATENCY-deep shift register aligned with RAM data.
- Tag exits pipeline: registered mN_ack for tagged port high one cycle, rddata <= ram_rddata, in_flight[port] cleared in the same edge.
- At most one ack asserted per cycle; rddata holds last value when no ack.
- Throughput: one grant per cycle; per-port at most one outstanding access.

## Timing
- Reset (rst_n=0 at edge): ram_rden=0, ram_addr=0, m0/m1/m2_ack=0, rddata=0, rr_ptr=0, in_flight=0, tag pipeline cleared. Accesses in flight at reset are dropped; no ack ever issued for them.
- Latency strobe→ack: RAM_LATENCY+1 cycles when port wins immediately (strobe sampled at edge N, ram_rden high after N, ack high after N+RAM_LATENCY).
- ack and rddata are registered outputs; no combinational path from any strobe/addr to any ack (masters' strobe depends on ack; loop forbidden).
- Address sampled only in grant cycle; addr changes afterward do not affect the access.
- Simultaneous grant and ack on the same port in one cycle impossible (in_flight); grant to port A and ack to port B in the same cycle permitted.
- Strobe deasserted before grant: request abandoned, nothing issued. Strobe deasserted after grant: access completes, ack still pulses.
- Worst-case wait for a continuously requesting port: 2 grants to others.

## Test plan
- Reset: hold rst_n=0 with all strobes high for 3 cycles -> ram_rden=0, all acks 0, rddata=0; release -> m0 granted first (rr_ptr=0).
- Single access, RAM_LATENCY=1: m2_strobe=1, m2_addr=15'h1234, RAM returns 32'hDEADBEEF -> ram_addr=15'h1234 one cycle later, m2_ack pulse with rddata=32'hDEADBEEF two cycles after strobe, exactly one cycle wide.
- Fairness: all three strobes held high (re-raised the cycle after each ack) for 30 cycles -> grant order 0,1,2,0,1,2…, each port 10±1 acks, no two acks same cycle.
- Latency sweep: RAM_LATENCY=1,2,3 with back-to-back m0/m1 requests -> ack-to-data alignment correct, ack at strobe+RAM_LATENCY+1, one ram_rden per cycle sustained.
- Late strobe drop: master keeps strobe high during its ack cycle -> no second grant for that port (in_flight), ram_rden count equals ack count.
- Reset mid-flight: RAM_LATENCY=3, assert rst_n=0 one cycle after grant of m1 -> no m1_ack ever appears; after release next m1 request completes normally.
